// File: rtl/vending_pkg.sv
// Shared constants and state type for the multi-product vending machine.
// Coin codes are common to the acceptor input and the change actuator output.
package vending_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_C1   = 2'b01;
   localparam logic [1:0] COIN_C2   = 2'b10;
   localparam logic [1:0] COIN_C3   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vm_state_t;

endpackage

// File: rtl/vm_change_select.sv
// Greedy change picker: largest coin whose value does not exceed the credit.
// Returns COIN_NONE with value 0 when the credit is below the smallest coin.
module vm_change_select
   import vending_pkg::*;
#(
   parameter int VAL_W = 8,
   parameter int COIN1 = 5,
   parameter int COIN2 = 10,
   parameter int COIN3 = 25
) (
   input  logic [VAL_W-1:0] i_credit,
   output logic [1:0]       o_code,
   output logic [VAL_W-1:0] o_value
);

   localparam logic [VAL_W-1:0] V1 = VAL_W'(COIN1);
   localparam logic [VAL_W-1:0] V2 = VAL_W'(COIN2);
   localparam logic [VAL_W-1:0] V3 = VAL_W'(COIN3);

   always_comb begin
      o_code  = COIN_NONE;
      o_value = '0;
      if (i_credit >= V3) begin
         o_code  = COIN_C3;
         o_value = V3;
      end else if (i_credit >= V2) begin
         o_code  = COIN_C2;
         o_value = V2;
      end else if (i_credit >= V1) begin
         o_code  = COIN_C1;
         o_value = V1;
      end
   end

endmodule

// File: rtl/vending_machine_mp.sv
// Multi-product vending machine: coin credit, per-product prices, cancel/refund
// and serial greedy change. All outputs are registered.
module vending_machine_mp
   import vending_pkg::*;
#(
   parameter int VAL_W  = 8,
   parameter int N_PROD = 4,
   parameter int COIN1  = 5,
   parameter int COIN2  = 10,
   parameter int COIN3  = 25,
   parameter logic [N_PROD*VAL_W-1:0] PRICES = {8'd30, 8'd25, 8'd20, 8'd15}
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [1:0]                i_in,
   input  logic [$clog2(N_PROD)-1:0] i_sel,
   input  logic                      i_buy,
   input  logic                      i_cancel,
   output logic                      o_out,
   output logic [$clog2(N_PROD)-1:0] o_out_id,
   output logic [1:0]                o_change,
   output logic                      o_change_busy,
   output logic [VAL_W-1:0]          o_credit,
   output logic                      o_coin_reject,
   output logic                      o_deny
);

   localparam int SEL_W = $clog2(N_PROD);
   localparam logic [VAL_W:0] MAX_CREDIT = {1'b0, {VAL_W{1'b1}}};
   localparam logic [SEL_W:0] NPROD_L    = (SEL_W+1)'(N_PROD);

   vm_state_t         r_state;
   logic [VAL_W-1:0]  r_credit;
   logic              r_out;
   logic [SEL_W-1:0]  r_out_id;
   logic [1:0]        r_change;
   logic              r_change_busy;
   logic              r_coin_reject;
   logic              r_deny;

   logic [VAL_W:0]    w_coin_val;
   logic [VAL_W:0]    w_sum;
   logic              w_coin_present;
   logic              w_coin_fits;
   logic [VAL_W-1:0]  w_price_tbl [N_PROD];
   logic [VAL_W-1:0]  w_price;
   logic              w_sel_ok;
   logic              w_can_buy;
   logic [1:0]        w_cs_code;
   logic [VAL_W-1:0]  w_cs_value;
   logic              w_chg_avail;

   always_comb begin
      w_coin_val = '0;
      case (i_in)
         COIN_C1: w_coin_val = (VAL_W+1)'(COIN1);
         COIN_C2: w_coin_val = (VAL_W+1)'(COIN2);
         COIN_C3: w_coin_val = (VAL_W+1)'(COIN3);
         default: w_coin_val = '0;
      endcase
   end

   // Sum carried one bit wider so an overflowing coin is caught, not wrapped.
   assign w_coin_present = (i_in != COIN_NONE);
   assign w_sum          = {1'b0, r_credit} + w_coin_val;
   assign w_coin_fits    = (w_sum <= MAX_CREDIT);

   for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
      assign w_price_tbl[gi] = PRICES[gi*VAL_W +: VAL_W];
   end

   assign w_sel_ok  = ({1'b0, i_sel} < NPROD_L);
   assign w_price   = w_sel_ok ? w_price_tbl[i_sel] : '0;
   assign w_can_buy = w_sel_ok && (r_credit >= w_price);

   vm_change_select #(
      .VAL_W (VAL_W),
      .COIN1 (COIN1),
      .COIN2 (COIN2),
      .COIN3 (COIN3)
   ) u_change_select (
      .i_credit (r_credit),
      .o_code   (w_cs_code),
      .o_value  (w_cs_value)
   );

   assign w_chg_avail = (w_cs_code != COIN_NONE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_out         <= 1'b0;
         r_out_id      <= '0;
         r_change      <= COIN_NONE;
         r_change_busy <= 1'b0;
         r_coin_reject <= 1'b0;
         r_deny        <= 1'b0;
      end else begin
         r_out         <= 1'b0;
         r_coin_reject <= 1'b0;
         r_deny        <= 1'b0;
         r_change      <= COIN_NONE;
         r_change_busy <= 1'b0;
         case (r_state)
            ST_IDLE, ST_CREDIT: begin
               if (i_cancel) begin
                  // Cancel beats buy; any coin this cycle goes straight back.
                  r_coin_reject <= w_coin_present;
                  if (r_state == ST_CREDIT) begin
                     if (w_chg_avail) begin
                        r_change      <= w_cs_code;
                        r_change_busy <= 1'b1;
                        r_credit      <= r_credit - w_cs_value;
                        r_state       <= ST_CHANGE;
                     end else begin
                        r_credit <= '0;
                        r_state  <= ST_IDLE;
                     end
                  end
               end else if (i_buy && w_can_buy) begin
                  r_coin_reject <= w_coin_present;
                  r_credit      <= r_credit - w_price;
                  r_out         <= 1'b1;
                  r_out_id      <= i_sel;
                  r_state       <= ST_VEND;
               end else begin
                  r_deny <= i_buy;
                  if (w_coin_present) begin
                     if (w_coin_fits) begin
                        r_credit <= w_sum[VAL_W-1:0];
                        r_state  <= ST_CREDIT;
                     end else begin
                        r_coin_reject <= 1'b1;
                     end
                  end
               end
            end
            ST_VEND, ST_CHANGE: begin
               // Zero credit or a sub-coin residue both end in IDLE with credit 0.
               r_coin_reject <= w_coin_present;
               if (w_chg_avail) begin
                  r_change      <= w_cs_code;
                  r_change_busy <= 1'b1;
                  r_credit      <= r_credit - w_cs_value;
                  r_state       <= ST_CHANGE;
               end else begin
                  r_credit <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_credit <= '0;
            end
         endcase
      end
   end

   assign o_out         = r_out;
   assign o_out_id      = r_out_id;
   assign o_change      = r_change;
   assign o_change_busy = r_change_busy;
   assign o_credit      = r_credit;
   assign o_coin_reject = r_coin_reject;
   assign o_deny        = r_deny;

endmodule

// File: tb/tb_vending_machine_mp.sv
// Bench for vending_machine_mp: directed test-plan steps then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_vending_machine_mp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] tb_in = 2'b00;
   logic [1:0] tb_sel = 2'b00;
   logic       tb_buy = 1'b0;
   logic       tb_cancel = 1'b0;

   logic       d_out;
   logic [1:0] d_out_id;
   logic [1:0] d_change;
   logic       d_busy;
   logic [7:0] d_credit;
   logic       d_rej;
   logic       d_deny;

   logic [1:0] s_in = 2'b00;
   logic       s_out;
   logic [1:0] s_out_id;
   logic [1:0] s_change;
   logic       s_busy;
   logic [5:0] s_credit;
   logic       s_rej;
   logic       s_deny;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vending_machine_mp dut (
      .i_clk(clk), .i_rst(rst), .i_in(tb_in), .i_sel(tb_sel), .i_buy(tb_buy),
      .i_cancel(tb_cancel), .o_out(d_out), .o_out_id(d_out_id), .o_change(d_change),
      .o_change_busy(d_busy), .o_credit(d_credit), .o_coin_reject(d_rej), .o_deny(d_deny)
   );

   vending_machine_mp #(
      .VAL_W(6), .PRICES({6'd30, 6'd25, 6'd20, 6'd15})
   ) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_in(s_in), .i_sel(2'b00), .i_buy(1'b0),
      .i_cancel(1'b0), .o_out(s_out), .o_out_id(s_out_id), .o_change(s_change),
      .o_change_busy(s_busy), .o_credit(s_credit), .o_coin_reject(s_rej), .o_deny(s_deny)
   );

   // Reference model: credit as an integer, and a queue of the output cycles
   // still owed by an in-progress vend/refund (machine is busy while non-empty).
   typedef struct {
      int         credit;
      logic [1:0] change;
      logic       busy;
   } step_t;

   step_t q[$];
   int    m_credit = 0;
   int    m_id     = 0;
   int    price [4] = '{15, 20, 25, 30};
   int    cval  [4] = '{0, 5, 10, 25};

   logic       e_out, e_busy, e_rej, e_deny;
   logic [1:0] e_change;
   int         e_credit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Greedy refund of c: one coin per cycle, then a closing idle cycle.
   task automatic push_change(input int c);
      int rem;
      int code;
      rem = c;
      while (rem >= 5) begin
         code = (rem >= 25) ? 3 : (rem >= 10) ? 2 : 1;
         rem -= cval[code];
         q.push_back('{rem, 2'(code), 1'b1});
      end
      q.push_back('{0, 2'b00, 1'b0});
   endtask

   task automatic model_step(input logic [1:0] c, input logic [1:0] s, input logic b, input logic k);
      step_t t;
      e_out = 0; e_rej = 0; e_deny = 0; e_change = 2'b00; e_busy = 0;
      e_credit = m_credit;
      if (q.size() > 0) begin
         t = q.pop_front();
         e_credit = t.credit; e_change = t.change; e_busy = t.busy;
         e_rej = (c != 2'b00);
      end else if (k) begin
         e_rej = (c != 2'b00);
         if (m_credit > 0) begin
            push_change(m_credit);
            t = q.pop_front();
            e_credit = t.credit; e_change = t.change; e_busy = t.busy;
         end
      end else if (b && m_credit >= price[s]) begin
         e_rej = (c != 2'b00);
         e_out = 1;
         m_id = int'(s);
         e_credit = m_credit - price[s];
         push_change(e_credit);
      end else begin
         e_deny = b;
         if (c != 2'b00) begin
            if (m_credit + cval[c] > 255) e_rej = 1;
            else e_credit = m_credit + cval[c];
         end
      end
      m_credit = e_credit;
   endtask

   task automatic cycle(input logic [1:0] c, input logic [1:0] s, input logic b, input logic k);
      @(negedge clk);
      tb_in = c; tb_sel = s; tb_buy = b; tb_cancel = k;
      model_step(c, s, b, k);
      @(posedge clk);
      #1;
      check("out",         32'(d_out),    32'(e_out));
      check("out_id",      32'(d_out_id), 32'(m_id));
      check("change",      32'(d_change), 32'(e_change));
      check("change_busy", 32'(d_busy),   32'(e_busy));
      check("credit",      32'(d_credit), 32'(e_credit));
      check("coin_reject", 32'(d_rej),    32'(e_rej));
      check("deny",        32'(d_deny),   32'(e_deny));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out"},    32'(d_out),    0);
      check({tag, "_out_id"}, 32'(d_out_id), 0);
      check({tag, "_change"}, 32'(d_change), 0);
      check({tag, "_busy"},   32'(d_busy),   0);
      check({tag, "_credit"}, 32'(d_credit), 0);
      check({tag, "_rej"},    32'(d_rej),    0);
      check({tag, "_deny"},   32'(d_deny),   0);
   endtask

   task automatic sat_coin(input logic [1:0] c, input int exp_credit, input logic exp_rej);
      @(negedge clk);
      s_in = c;
      @(posedge clk);
      #1;
      check("sat_credit", 32'(s_credit), 32'(exp_credit));
      check("sat_reject", 32'(s_rej),    32'(exp_rej));
   endtask

   initial begin
      #3;
      check_zero("reset");
      @(negedge clk);
      rst = 0;

      // Saturation on the 6-bit instance; the main DUT idles in IDLE meanwhile.
      sat_coin(2'b11, 25, 1'b0);
      sat_coin(2'b11, 50, 1'b0);
      sat_coin(2'b11, 50, 1'b1);
      sat_coin(2'b00, 50, 1'b0);
      check("sat_busy", 32'(s_busy), 0);

      // Exact price
      cycle(2'b10, 0, 0, 0); cycle(2'b01, 0, 0, 0); cycle(2'b00, 0, 1, 0); idle(3);
      // Change due
      cycle(2'b10, 0, 0, 0); cycle(2'b10, 0, 0, 0); cycle(2'b00, 0, 1, 0); idle(3);
      // Refund 25+25
      cycle(2'b11, 0, 0, 0); cycle(2'b11, 0, 0, 0); cycle(2'b00, 0, 0, 1); idle(3);
      // Insufficient credit, then clear it with a refund
      cycle(2'b10, 0, 0, 0); cycle(2'b00, 3, 1, 0); cycle(2'b00, 0, 0, 1); idle(3);
      // Coin during CHANGE
      cycle(2'b10, 0, 0, 0); cycle(2'b10, 0, 0, 0); cycle(2'b00, 0, 0, 1);
      cycle(2'b01, 0, 0, 0); idle(3);
      // buy and cancel together: cancel wins
      cycle(2'b10, 0, 0, 0); cycle(2'b10, 0, 0, 0); cycle(2'b00, 0, 1, 1); idle(3);
      // Asynchronous reset in the middle of a refund
      cycle(2'b11, 0, 0, 0); cycle(2'b11, 0, 0, 0); cycle(2'b00, 0, 0, 1);
      check("midchg_change", 32'(d_change), 3);
      tb_in = 0; tb_buy = 0; tb_cancel = 0;
      #2;
      rst = 1;
      #1;
      check_zero("async_rst");
      m_credit = 0; m_id = 0; q.delete();
      @(negedge clk);
      rst = 0;
      idle(2);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         logic [1:0] c;
         c = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
         cycle(c, 2'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0),
               ($urandom_range(0, 11) == 0));
      end
      cycle(2'b00, 0, 0, 1);
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end

endmodule
